wbuf_id_alloc: RTL and testbench

- Free-ID pool sitting directly upstream of the write buffer.
- Hands out write-buffer entry IDs to the crossbar, which stamps each ID into the wbuf_id field of its write request.
- Reclaims IDs from the write buffer's free response (xbar_rsp_free_valid / xbar_rsp_free_id) once the entry has been read out.
- Guarantees that no ID is held by two outstanding writes and that the crossbar stalls when every entry is occupied.

---
 rtl/wbuf_id_alloc.sv | 110 +++++++++++
 tb/tb_wbuf_id_alloc.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/wbuf_id_alloc.sv
`default_nettype none
// ============================================================================
//  Module   : wbuf_id_alloc
//  Purpose  : Free-ID pool for the write buffer; issues entry IDs to the
//             crossbar and reclaims them from the buffer's free response.
//  Revision : 1.0  initial release
// ============================================================================
module wbuf_id_alloc #(
    parameter int WBUF_SIZE = 8,
    parameter int ID_W      = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 alloc_valid,
    input  logic                 alloc_ready,
    output logic [ID_W-1:0]      alloc_id,
    input  logic                 free_valid,
    input  logic [ID_W-1:0]      free_id,
    output logic [ID_W:0]        free_cnt,
    output logic [WBUF_SIZE-1:0] in_use,
    output logic                 err_free_unalloc,
    output logic                 err_alloc_empty
);

    localparam logic [ID_W:0]   c_FULL_CNT = (ID_W + 1)'(WBUF_SIZE);
    localparam logic [ID_W-1:0] c_PTR_ONE  = ID_W'(1);
    localparam logic [ID_W:0]   c_CNT_ONE  = (ID_W + 1)'(1);

    logic [ID_W-1:0]      r_fifo [WBUF_SIZE];
    logic [ID_W-1:0]      r_rd_ptr;
    logic [ID_W-1:0]      r_wr_ptr;
    logic [ID_W:0]        r_free_cnt;
    logic [WBUF_SIZE-1:0] r_in_use;
    logic                 r_err_free_unalloc;
    logic                 r_err_alloc_empty;

    logic                 w_alloc_valid;
    logic                 w_alloc_xfer;
    logic                 w_legal_free;
    logic                 w_illegal_free;
    logic [ID_W:0]        w_free_cnt_nxt;
    logic [WBUF_SIZE-1:0] w_in_use_nxt;

    assign w_alloc_valid  = (r_free_cnt != '0);
    assign w_alloc_xfer   = w_alloc_valid & alloc_ready;
    // Legality uses the registered in_use, so freeing the ID being issued
    // in the same cycle is rejected rather than forwarded.
    assign w_legal_free   = free_valid &  r_in_use[free_id];
    assign w_illegal_free = free_valid & ~r_in_use[free_id];

    always_comb begin
        w_free_cnt_nxt = r_free_cnt;
        case ({w_legal_free, w_alloc_xfer})
            2'b10:   w_free_cnt_nxt = r_free_cnt + c_CNT_ONE;
            2'b01:   w_free_cnt_nxt = r_free_cnt - c_CNT_ONE;
            default: w_free_cnt_nxt = r_free_cnt;
        endcase
    end

    // A legal free always targets an allocated ID and the issued ID is
    // always free, so the set and clear never hit the same bit.
    always_comb begin
        w_in_use_nxt = r_in_use;
        if (w_alloc_xfer) begin
            w_in_use_nxt[r_fifo[r_rd_ptr]] = 1'b1;
        end
        if (w_legal_free) begin
            w_in_use_nxt[free_id] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < WBUF_SIZE; k++) begin
                r_fifo[k] <= ID_W'(k);
            end
            r_rd_ptr           <= '0;
            r_wr_ptr           <= '0;
            r_free_cnt         <= c_FULL_CNT;
            r_in_use           <= '0;
            r_err_free_unalloc <= 1'b0;
            r_err_alloc_empty  <= 1'b0;
        end else begin
            if (w_legal_free) begin
                r_fifo[r_wr_ptr] <= free_id;
                r_wr_ptr         <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_alloc_xfer) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_free_cnt <= w_free_cnt_nxt;
            r_in_use   <= w_in_use_nxt;
            if (w_illegal_free) begin
                r_err_free_unalloc <= 1'b1;
            end
            if (alloc_ready && !w_alloc_valid) begin
                r_err_alloc_empty <= 1'b1;
            end
        end
    end

    assign alloc_valid      = w_alloc_valid;
    assign alloc_id         = r_fifo[r_rd_ptr];
    assign free_cnt         = r_free_cnt;
    assign in_use           = r_in_use;
    assign err_free_unalloc = r_err_free_unalloc;
    assign err_alloc_empty  = r_err_alloc_empty;

endmodule
`default_nettype wire

// File: tb/tb_wbuf_id_alloc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wbuf_id_alloc
//  Purpose  : Directed and randomized checks of wbuf_id_alloc against a
//             queue-based model of the free-ID pool.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wbuf_id_alloc;

    logic       clk;
    logic       rst;
    logic       alloc_valid;
    logic       alloc_ready;
    logic [2:0] alloc_id;
    logic       free_valid;
    logic [2:0] free_id;
    logic [3:0] free_cnt;
    logic [7:0] in_use;
    logic       err_free_unalloc;
    logic       err_alloc_empty;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pool of free IDs in release order plus per-ID flags.
    int       pool[$];
    bit [7:0] m_used;
    bit       m_err_free;
    bit       m_err_empty;

    wbuf_id_alloc #(.WBUF_SIZE(8), .ID_W(3)) dut (
        .clk              (clk),
        .rst              (rst),
        .alloc_valid      (alloc_valid),
        .alloc_ready      (alloc_ready),
        .alloc_id         (alloc_id),
        .free_valid       (free_valid),
        .free_id          (free_id),
        .free_cnt         (free_cnt),
        .in_use           (in_use),
        .err_free_unalloc (err_free_unalloc),
        .err_alloc_empty  (err_alloc_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: drive inputs, step the model at the edge, return at negedge.
    task automatic cycle(input logic r, input logic ar, input logic fv, input logic [2:0] fid);
        bit legal;
        int id;
        rst         = r;
        alloc_ready = ar;
        free_valid  = fv;
        free_id     = fid;
        @(posedge clk);
        if (r) begin
            pool.delete();
            for (int i = 0; i < 8; i++) pool.push_back(i);
            m_used      = '0;
            m_err_free  = 0;
            m_err_empty = 0;
        end else begin
            legal = fv && m_used[fid];
            if (fv && !m_used[fid]) m_err_free = 1;
            if (ar && pool.size() == 0) m_err_empty = 1;
            if (ar && pool.size() != 0) begin
                id = pool.pop_front();
                m_used[id] = 1;
            end
            if (legal) begin
                pool.push_back(int'(fid));
                m_used[fid] = 0;
            end
        end
        @(negedge clk);
        rst         = 1'b0;
        alloc_ready = 1'b0;
        free_valid  = 1'b0;
        free_id     = 3'd0;
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 0);
        n_checks++; if (alloc_valid !== 1'b1) begin n_errors++; $display("FAIL reset_valid got %b want 1", alloc_valid); end
        n_checks++; if (alloc_id !== 3'd0) begin n_errors++; $display("FAIL reset_id got %0d want 0", alloc_id); end
        n_checks++; if (free_cnt !== 4'd8) begin n_errors++; $display("FAIL reset_cnt got %0d want 8", free_cnt); end
        n_checks++; if (in_use !== 8'h00) begin n_errors++; $display("FAIL reset_in_use got %h want 00", in_use); end
        n_checks++; if ({err_free_unalloc, err_alloc_empty} !== 2'b00) begin n_errors++; $display("FAIL reset_err got %b%b want 00", err_free_unalloc, err_alloc_empty); end
    endtask

    task automatic test_drain();
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (alloc_valid !== 1'b1 || alloc_id !== 3'(i)) begin n_errors++; $display("FAIL drain_id[%0d] got v=%b id=%0d want v=1 id=%0d", i, alloc_valid, alloc_id, i); end
            n_checks++; if (free_cnt !== 4'(8 - i)) begin n_errors++; $display("FAIL drain_cnt[%0d] got %0d want %0d", i, free_cnt, 8 - i); end
            cycle(0, 1, 0, 0);
        end
        n_checks++; if (alloc_valid !== 1'b0 || free_cnt !== 4'd0) begin n_errors++; $display("FAIL drain_empty got v=%b cnt=%0d want v=0 cnt=0", alloc_valid, free_cnt); end
        n_checks++; if (in_use !== 8'hFF) begin n_errors++; $display("FAIL drain_in_use got %h want ff", in_use); end
        n_checks++; if ({err_free_unalloc, err_alloc_empty} !== 2'b00) begin n_errors++; $display("FAIL drain_err got %b%b want 00", err_free_unalloc, err_alloc_empty); end
    endtask

    // Pool empty on entry (follows test_drain); ready held high throughout.
    task automatic test_refill_latency();
        n_checks++; if (alloc_valid !== 1'b0) begin n_errors++; $display("FAIL refill_cycN_valid got %b want 0", alloc_valid); end
        cycle(0, 1, 1, 3'd5);
        n_checks++; if (alloc_valid !== 1'b1 || alloc_id !== 3'd5) begin n_errors++; $display("FAIL refill_cycN1 got v=%b id=%0d want v=1 id=5", alloc_valid, alloc_id); end
        n_checks++; if (free_cnt !== 4'd1 || in_use[5] !== 1'b0) begin n_errors++; $display("FAIL refill_cycN1_state got cnt=%0d use5=%b want cnt=1 use5=0", free_cnt, in_use[5]); end
        cycle(0, 1, 0, 0);
        n_checks++; if (free_cnt !== 4'd0 || in_use !== 8'hFF) begin n_errors++; $display("FAIL refill_cycN2 got cnt=%0d use=%h want cnt=0 use=ff", free_cnt, in_use); end
    endtask

    task automatic test_simultaneous();
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0);
        cycle(0, 0, 1, 3'd0);
        n_checks++; if (free_cnt !== 4'd3 || alloc_id !== 3'd6) begin n_errors++; $display("FAIL simul_setup got cnt=%0d id=%0d want cnt=3 id=6", free_cnt, alloc_id); end
        cycle(0, 1, 1, 3'd2);
        n_checks++; if (free_cnt !== 4'd3) begin n_errors++; $display("FAIL simul_cnt got %0d want 3", free_cnt); end
        n_checks++; if (in_use[2] !== 1'b0 || in_use[6] !== 1'b1) begin n_errors++; $display("FAIL simul_in_use got %h want bit2=0 bit6=1", in_use); end
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (alloc_id !== 3'(i == 0 ? 7 : 0)) begin n_errors++; $display("FAIL simul_order[%0d] got %0d want %0d", i, alloc_id, i == 0 ? 7 : 0); end
            cycle(0, 1, 0, 0);
            n_checks++; if (in_use[2] !== 1'b0) begin n_errors++; $display("FAIL simul_hold2[%0d] got %b want 0", i, in_use[2]); end
        end
        n_checks++; if (alloc_id !== 3'd2) begin n_errors++; $display("FAIL simul_reissue got %0d want 2", alloc_id); end
        cycle(0, 1, 0, 0);
        n_checks++; if (in_use[2] !== 1'b1 || free_cnt !== 4'd0) begin n_errors++; $display("FAIL simul_final got use2=%b cnt=%0d want 1 0", in_use[2], free_cnt); end
    endtask

    task automatic test_double_free();
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0);
        cycle(0, 0, 1, 3'd4);
        n_checks++; if (free_cnt !== 4'd4 || err_free_unalloc !== 1'b0) begin n_errors++; $display("FAIL dfree_first got cnt=%0d err=%b want 4 0", free_cnt, err_free_unalloc); end
        cycle(0, 0, 1, 3'd4);
        n_checks++; if (free_cnt !== 4'd4 || err_free_unalloc !== 1'b1) begin n_errors++; $display("FAIL dfree_second got cnt=%0d err=%b want 4 1", free_cnt, err_free_unalloc); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (alloc_id !== 3'(i == 3 ? 4 : 5 + i)) begin n_errors++; $display("FAIL dfree_order[%0d] got %0d want %0d", i, alloc_id, i == 3 ? 4 : 5 + i); end
            cycle(0, 1, 0, 0);
        end
        n_checks++; if (alloc_valid !== 1'b0 || free_cnt !== 4'd0) begin n_errors++; $display("FAIL dfree_no_push got v=%b cnt=%0d want 0 0", alloc_valid, free_cnt); end
    endtask

    task automatic test_reset_mid();
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0);
        cycle(0, 0, 1, 3'd6);
        n_checks++; if (err_free_unalloc !== 1'b1) begin n_errors++; $display("FAIL rstmid_pre_err got %b want 1", err_free_unalloc); end
        cycle(1, 0, 1, 3'd1);
        n_checks++; if (free_cnt !== 4'd8 || in_use !== 8'h00) begin n_errors++; $display("FAIL rstmid_state got cnt=%0d use=%h want 8 00", free_cnt, in_use); end
        n_checks++; if (alloc_id !== 3'd0 || alloc_valid !== 1'b1) begin n_errors++; $display("FAIL rstmid_id got v=%b id=%0d want 1 0", alloc_valid, alloc_id); end
        n_checks++; if ({err_free_unalloc, err_alloc_empty} !== 2'b00) begin n_errors++; $display("FAIL rstmid_err got %b%b want 00", err_free_unalloc, err_alloc_empty); end
    endtask

    task automatic test_alloc_empty();
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
        n_checks++; if (err_alloc_empty !== 1'b1 || free_cnt !== 4'd0 || alloc_valid !== 1'b0) begin n_errors++; $display("FAIL aempty got err=%b cnt=%0d v=%b want 1 0 0", err_alloc_empty, free_cnt, alloc_valid); end
        cycle(0, 0, 1, 3'd3);
        cycle(0, 0, 1, 3'd6);
        n_checks++; if (alloc_id !== 3'd3 || free_cnt !== 4'd2) begin n_errors++; $display("FAIL aempty_ptr got id=%0d cnt=%0d want 3 2", alloc_id, free_cnt); end
        cycle(0, 1, 0, 0);
        n_checks++; if (alloc_id !== 3'd6 || err_alloc_empty !== 1'b1) begin n_errors++; $display("FAIL aempty_sticky got id=%0d err=%b want 6 1", alloc_id, err_alloc_empty); end
        cycle(1, 0, 0, 0);
        n_checks++; if (err_alloc_empty !== 1'b0) begin n_errors++; $display("FAIL aempty_clear got %b want 0", err_alloc_empty); end
    endtask

    task automatic test_random();
        logic       r, ar, fv;
        logic [2:0] fid;
        cycle(1, 0, 0, 0);
        for (int n = 0; n < 600; n++) begin
            n_checks++; if (alloc_valid !== (pool.size() != 0)) begin n_errors++; $display("FAIL rnd_valid[%0d] got %b want %b", n, alloc_valid, pool.size() != 0); end
            if (pool.size() != 0) begin
                n_checks++; if (alloc_id !== 3'(pool[0])) begin n_errors++; $display("FAIL rnd_id[%0d] got %0d want %0d", n, alloc_id, pool[0]); end
            end
            n_checks++; if (free_cnt !== 4'(pool.size())) begin n_errors++; $display("FAIL rnd_cnt[%0d] got %0d want %0d", n, free_cnt, pool.size()); end
            n_checks++; if (in_use !== m_used) begin n_errors++; $display("FAIL rnd_in_use[%0d] got %h want %h", n, in_use, m_used); end
            n_checks++; if (err_free_unalloc !== m_err_free || err_alloc_empty !== m_err_empty) begin n_errors++; $display("FAIL rnd_err[%0d] got %b%b want %b%b", n, err_free_unalloc, err_alloc_empty, m_err_free, m_err_empty); end
            r   = ($urandom_range(0, 79) == 0);
            ar  = ($urandom_range(0, 99) < 55);
            fv  = ($urandom_range(0, 99) < 50);
            fid = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) < 8 && m_used != '0) begin
                while (!m_used[fid]) fid = 3'($urandom_range(0, 7));
            end
            cycle(r, ar, fv, fid);
        end
    endtask

    initial begin
        rst         = 1'b1;
        alloc_ready = 1'b0;
        free_valid  = 1'b0;
        free_id     = 3'd0;
        @(negedge clk);
        test_reset();
        test_drain();
        test_refill_latency();
        test_simultaneous();
        test_double_free();
        test_reset_mid();
        test_alloc_empty();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
